// File: rtl/game_screen_sequencer.sv
// game_screen_sequencer: pixel coordinate pipeline, screen mux and frame-synchronous wipe sequencer
module game_screen_sequencer #(
  parameter int NUM_SCREENS = 10,
  parameter int WIPE_STEP   = 8,
  parameter int HOLD_FRAMES = 120
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_begin,
  input  logic [12:0]              pixel_index,
  input  logic                     req_valid,
  input  logic [3:0]               req_screen,
  output logic                     req_ready,
  input  logic                     auto_en,
  input  logic [16*NUM_SCREENS-1:0] screen_data,
  output logic [6:0]               x,
  output logic [5:0]               y,
  output logic [3:0]               cur_screen,
  output logic [3:0]               nxt_screen,
  output logic                     busy,
  output logic [15:0]              oled_data
);
  typedef enum logic [1:0] {SHOW, ARMED, WIPE} state_t;
  localparam logic [7:0]  STEP  = 8'(WIPE_STEP);
  localparam logic [6:0]  FIRST = (WIPE_STEP >= 96) ? 7'd96 : 7'(WIPE_STEP);
  localparam logic [16:0] HOLD  = 17'(HOLD_FRAMES);
  localparam logic [3:0]  LAST  = 4'(NUM_SCREENS - 1);
  state_t state, state_n;
  logic [3:0]  cur_n, nxt_n, pend_screen, pend_screen_n, tgt;
  logic [6:0]  wipe_col, wipe_col_n;
  logic [7:0]  col_sum;
  logic [15:0] hold, hold_n, cur_px, nxt_px;
  logic        pend_valid, pend_valid_n, oob, ext, take, tgt_ok;
  assign req_ready = !pend_valid;
  assign busy      = state == WIPE;
  assign ext       = req_valid && req_ready;
  assign take      = pend_valid || ext;
  assign tgt       = pend_valid ? pend_screen : req_screen;
  assign tgt_ok    = {1'b0, tgt} < 5'(NUM_SCREENS);
  assign col_sum   = {1'b0, wipe_col} + STEP;
  // select the colours of the displayed and incoming screens; unknown selects read black
  always_comb begin
    cur_px = '0;
    nxt_px = '0;
    for (int k = 0; k < NUM_SCREENS; k++) begin
      if (cur_screen == 4'(k)) cur_px = screen_data[16*k +: 16];
      if (nxt_screen == 4'(k)) nxt_px = screen_data[16*k +: 16];
    end
  end
  // next-state: request handling, auto-advance and wipe progression
  always_comb begin
    state_n       = state;
    cur_n         = cur_screen;
    nxt_n         = nxt_screen;
    wipe_col_n    = wipe_col;
    hold_n        = auto_en ? hold : '0;
    pend_valid_n  = pend_valid;
    pend_screen_n = pend_screen;
    case (state)
      SHOW: begin
        if (take) begin
          pend_valid_n = 1'b0;
          if (tgt_ok && tgt != cur_screen) begin
            nxt_n   = tgt;
            state_n = ARMED;
          end else if (tgt_ok) hold_n = '0;
        end else if (auto_en && frame_begin) begin
          if ({1'b0, hold} + 17'd1 >= HOLD) begin
            hold_n  = '0;
            nxt_n   = (cur_screen == LAST) ? 4'd0 : cur_screen + 4'd1;
            state_n = ARMED;
          end else hold_n = hold + 16'd1;
        end
      end
      ARMED: begin
        if (ext && tgt_ok) nxt_n = tgt;
        if (frame_begin) begin
          state_n    = WIPE;
          wipe_col_n = FIRST;
        end
      end
      WIPE: begin
        if (ext && tgt_ok) begin
          pend_valid_n  = 1'b1;
          pend_screen_n = tgt;
        end
        if (frame_begin) begin
          if (wipe_col == 7'd96) begin
            state_n    = SHOW;
            cur_n      = nxt_screen;
            wipe_col_n = '0;
            hold_n     = '0;
          end else wipe_col_n = (col_sum >= 8'd96) ? 7'd96 : col_sum[6:0];
        end
      end
      default: state_n = SHOW;
    endcase
  end
  // sequencer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SHOW;
      cur_screen  <= '0;
      nxt_screen  <= '0;
      wipe_col    <= '0;
      hold        <= '0;
      pend_valid  <= 1'b0;
      pend_screen <= '0;
    end else begin
      state       <= state_n;
      cur_screen  <= cur_n;
      nxt_screen  <= nxt_n;
      wipe_col    <= wipe_col_n;
      hold        <= hold_n;
      pend_valid  <= pend_valid_n;
      pend_screen <= pend_screen_n;
    end
  end
  // two-stage pixel pipeline: index to x/y, then renderer colour to panel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x         <= '0;
      y         <= '0;
      oob       <= 1'b0;
      oled_data <= '0;
    end else begin
      if (pixel_index < 13'd6144) begin
        x   <= 7'(pixel_index % 13'd96);
        y   <= 6'(pixel_index / 13'd96);
        oob <= 1'b0;
      end else oob <= 1'b1;
      oled_data <= oob ? '0 : (state == WIPE && x < wipe_col) ? nxt_px : cur_px;
    end
  end
endmodule
